// File: rtl/mod7_count_monitor.sv
// mod7_count_monitor: synchronise, glitch-filter and sequence-check a ripple mod-7 count.
// Define MOD7_MON_SEG_EN to include the seven-segment decoder; otherwise seg is tied low.
module mod7_count_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cnt,
  input  logic              clr,
  output logic [2:0]        cnt_q,
  output logic              valid,
  output logic              step,
  output logic              wrap,
  output logic              err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [6:0]        seg
);
  typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;
  localparam logic [2:0] SC = 3'(STABLE_CYCLES);
  state_t state, st_eff, state_n;
  logic [2:0] s1, s2, stab, succ;
  logic acc, step_n, wrap_n;
  logic [WRAP_W-1:0] wc_b, wc_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      stab <= '0;
      cnt_q <= '0;
      state <= IDLE;
      step <= 1'b0;
      wrap <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      s1 <= cnt;
      s2 <= s1;
      // s1 != s2 means s2 changes on this edge, so its run length restarts at 1
      stab <= s1 != s2 ? 3'd1 : stab == SC ? SC : stab + 3'd1;
      if (acc) cnt_q <= s2;
      state <= state_n;
      step <= step_n;
      wrap <= wrap_n;
      wrap_cnt <= wc_n;
    end
  // clr leaves ERR before any acceptance on the same edge is judged
  always_comb begin
    st_eff = state == ERR && clr ? TRACK : state;
    acc = stab == SC && (s2 != cnt_q || state == IDLE);
    succ = cnt_q == 3'd6 ? 3'd0 : cnt_q == 3'd7 ? 3'd1 : cnt_q + 3'd1;
    step_n = acc && st_eff == TRACK && s2 == succ;
    wrap_n = step_n && cnt_q == 3'd6;
    state_n = !acc ? st_eff : st_eff == IDLE ? TRACK : st_eff == TRACK && s2 != succ ? ERR : st_eff;
    wc_b = clr ? '0 : wrap_cnt;
    wc_n = wrap_n && !(&wc_b) ? wc_b + WRAP_W'(1) : wc_b;
  end
  assign valid = state != IDLE;
  assign err = state == ERR;
`ifdef MOD7_MON_SEG_EN
  localparam logic [6:0] SEG [0:7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
  assign seg = valid ? SEG[cnt_q] : 7'h40;
`else
  assign seg = 7'h00;
`endif
endmodule

// File: tb/tb_mod7_count_monitor.sv
// tb_mod7_count_monitor: directed scoreboard bench for mod7_count_monitor.
module tb_mod7_count_monitor;
  logic clk = 0, reset = 0, clr = 0;
  logic [2:0] cnt = 0;
  logic [2:0] cnt_q, cnt_q2;
  logic valid, step, wrap, err, valid2, step2, wrap2, err2;
  logic [7:0] wrap_cnt;
  logic [1:0] wrap_cnt2;
  logic [6:0] seg, seg2;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct { int cyc; logic [21:0] v; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic pv = 0, pe = 0;
  logic [2:0] pq = 0;
  logic [7:0] pw = 0;
  logic [21:0] act;

  mod7_count_monitor dut (
    .clk(clk), .reset(reset), .cnt(cnt), .clr(clr), .cnt_q(cnt_q), .valid(valid),
    .step(step), .wrap(wrap), .err(err), .wrap_cnt(wrap_cnt), .seg(seg)
  );
  mod7_count_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .cnt(cnt), .clr(clr), .cnt_q(cnt_q2), .valid(valid2),
    .step(step2), .wrap(wrap2), .err(err2), .wrap_cnt(wrap_cnt2), .seg(seg2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_exp(input logic vld, input logic [2:0] v);
    logic [6:0] t [0:7];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
`ifdef MOD7_MON_SEG_EN
    return vld ? t[v] : 7'h40;
`else
    return 7'h00;
`endif
  endfunction

  task automatic push(input int c, input logic vld, input logic [2:0] q, input logic st,
                      input logic wr, input logic er, input logic [7:0] wc);
    exp_t x;
    x.cyc = c;
    x.v = {vld, q, st, wr, er, wc, seg_exp(vld, q)};
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h, want %h", n, a, x);
    end
  endtask

  // new value sampled next edge, lands in cnt_q 2 + STABLE_CYCLES edges after the drive
  task automatic drv(input logic [2:0] v, input logic st, input logic wr, input logic er,
                     input logic [7:0] wc);
    cnt = v;
    push(cyc + 4, 1'b1, v, st, wr, er, wc);
    tick(8);
  endtask

  always @(negedge clk) begin
    act = {valid, cnt_q, step, wrap, err, wrap_cnt, seg};
    if (!reset) begin
      pv = 0; pq = 0; pe = 0; pw = 0;
    end else begin
      if ({valid, cnt_q, err, wrap_cnt} != {pv, pq, pe, pw}) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got %h at cycle %0d, want no event", act, cyc);
        end else begin
          e = sb.pop_front();
          if (act !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
            fails++;
            $display("FAIL event: got %h at cycle %0d, want %h at cycle %0d", act, cyc, e.v, e.cyc);
          end
        end
      end else if (step || wrap) begin
        checks++;
        fails++;
        $display("FAIL stray_pulse: got step=%b wrap=%b at cycle %0d, want 0", step, wrap, cyc);
      end
      pv = valid; pq = cnt_q; pe = err; pw = wrap_cnt;
    end
  end

  initial begin
    #2;
    chk("reset_outs", {10'd0, valid, cnt_q, step, wrap, err, wrap_cnt, seg}, {25'd0, seg_exp(1'b0, 3'd0)});
    tick(3);
    reset = 1;
    push(-1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(8);
    for (int i = 1; i <= 6; i++) drv(3'(i), 1'b1, 1'b0, 1'b0, 8'd0);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 8'd1);
    drv(3'd1, 1'b1, 1'b0, 1'b0, 8'd1);
    drv(3'd2, 1'b1, 1'b0, 1'b0, 8'd1);
    drv(3'd5, 1'b0, 1'b0, 1'b1, 8'd1);
    clr = 1;
    push(cyc + 1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    clr = 0;
    tick(7);
    drv(3'd6, 1'b1, 1'b0, 1'b0, 8'd0);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 8'd1);
    for (int i = 1; i <= 3; i++) drv(3'(i), 1'b1, 1'b0, 1'b0, 8'd1);
    cnt = 3'd7;
    tick(1);
    cnt = 3'd3;
    tick(8);
    chk("glitch_hold", {29'd0, cnt_q}, 32'd3);
    drv(3'd4, 1'b1, 1'b0, 1'b0, 8'd1);
    #2 reset = 0;
    #1;
    chk("async_reset", {10'd0, valid, cnt_q, step, wrap, err, wrap_cnt, seg}, {25'd0, seg_exp(1'b0, 3'd0)});
    chk("async_reset_w2", {30'd0, wrap_cnt2}, 32'd0);
    tick(3);
    reset = 1;
    push(-1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(8);
    drv(3'd5, 1'b1, 1'b0, 1'b0, 8'd0);
    drv(3'd6, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int n = 1; n <= 5; n++) begin
      drv(3'd0, 1'b1, 1'b1, 1'b0, 8'(n));
      chk($sformatf("sat_w2_%0d", n), {30'd0, wrap_cnt2}, n < 3 ? n : 3);
      if (n < 5) for (int i = 1; i <= 6; i++) drv(3'(i), 1'b1, 1'b0, 1'b0, 8'(n));
    end
    tick(10);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending events, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mod7_count_monitor.md
# mod7_count_monitor

Synchronous consumer of the 3-bit ripple mod-7 count. It synchronises and glitch-filters the count, checks that each accepted value is the legal successor 0→1→…→6→0, and produces step/wrap pulses, a saturating wrap counter and a seven-segment code for display. It sits directly downstream of the mod-7 ripple counter, in the system `clk` domain.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical synchronised samples needed to accept a new value. Legal range 1–7.
- `WRAP_W`, default 8: width of `wrap_cnt`.
- `clk` in 1: system clock. All flops are on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cnt` in 3: raw count from the ripple counter. Asynchronous to `clk` and may glitch.
- `clr` in 1: synchronous clear of `err` and `wrap_cnt`. Active-high.
- `cnt_q` out 3: filtered, accepted count.
- `valid` out 1: high once the first value has been accepted after reset.
- `step` out 1: one-cycle pulse on each legal +1 advance, including 6→0.
- `wrap` out 1: one-cycle pulse on a legal 6→0 advance.
- `err` out 1: sticky illegal-sequence flag.
- `wrap_cnt` out WRAP_W: number of wraps. Saturates at all-ones.
- `seg` out 7: segment drive {g,f,e,d,c,b,a}, active-high.

## Operation
- Input path: 2-flop synchroniser `s1`→`s2` on all 3 bits.
- Stability counter `stab`:
  - reloads to 1 when `s2` differs from its previous value;
  - otherwise increments, saturating at `STABLE_CYCLES`.
- A candidate is accepted when `stab == STABLE_CYCLES` and `s2 != cnt_q`, or when the block is in IDLE. Acceptance loads `cnt_q` on that edge.
- FSM states:
  - IDLE (reset state): on first acceptance → TRACK. Sets `valid`. No `step`, `wrap` or `err`.
  - TRACK:
    - accepted value == (`cnt_q`+1) mod 7 → `step`.
    - If additionally `cnt_q`==6 and the new value is 0 → `wrap`, and `wrap_cnt`+1 (saturating).
    - Any other accepted value, or an accepted value of 7 → ERR. `err`=1, no `step`/`wrap`.
  - ERR: keeps accepting and tracking `cnt_q`. Never pulses `step`/`wrap`.
    - `clr` → TRACK. `err`=0, `wrap_cnt`=0.
    - `clr` is taken before any acceptance on the same edge, so that acceptance is evaluated in TRACK.
- `clr` in TRACK or IDLE clears `wrap_cnt` only; the state is unchanged.
- When `clr` and a wrap happen on the same edge, `wrap_cnt` becomes 1 (the clear is applied first, then the increment).
- `seg` is combinational from `cnt_q`:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07.
  - 0x40 (dash) while `valid`=0.
- Reset values: `s1`=`s2`=0, `stab`=0, `cnt_q`=0, `valid`=0, `step`=`wrap`=`err`=0, `wrap_cnt`=0, `seg`=0x40, state IDLE.

## Timing
- Numbering: E0 is the first `clk` rise that samples a new stable `cnt`.
  - `s2` updates at E1.
  - `cnt_q`/`step`/`wrap`/`err` update at E(1+`STABLE_CYCLES`); with the default, E3.
- `step` and `wrap` are high for exactly one cycle, coincident with the `cnt_q` update.
- A glitch on `s2` shorter than `STABLE_CYCLES` samples is never accepted.
- A value that returns to the current `cnt_q` produces no event.
- `reset` assertion mid-operation clears everything immediately, asynchronously. Deassertion is sampled at the next rising edge; the first acceptance after reset is treated as an IDLE acceptance.
- Inputs must change no faster than once per (`STABLE_CYCLES`+2) `clk` cycles for every value to be seen. Faster input is filtered; a skipped value shows up as `err`.

## Configuration
- `MOD7_MON_SEG_EN` defined: seven-segment decoder is present and `seg` behaves as specified above.
- `MOD7_MON_SEG_EN` undefined: no decoder logic; `seg` is tied to 7'h00. All other behaviour is identical.

## Test plan
- Reset, then hold `cnt`=0 → `valid`=1 at E3, `cnt_q`=0, no `step`, `seg`=0x3F (macro defined).
- Drive 0,1,…,6,0, each held 8 cycles → six `step` pulses for 0→1…5→6, plus `step` and `wrap` together at 6→0; `wrap_cnt`=1, `err`=0.
- While at 3, insert a 1-cycle glitch `cnt`=7, then return to 3 → no event; `cnt_q` stays 3.
- Jump 2→5, held 8 cycles → `err`=1, no `step`. Then `clr` → `err`=0, `wrap_cnt`=0. Then 5→6 → `step`.
- Run `WRAP_W`=2 through 5 full wraps → `wrap_cnt` saturates at 3 with no rollover.
- Assert `reset` while `cnt_q`=4 → all outputs at reset values immediately; after release the first value is accepted with no `err`.
